// File: rtl/tv_player_checker.sv
// tv_player_checker: on-board test-vector player and response checker.
// Plays stored stimulus words onto a lab DUT, waits SETTLE cycles, compares the
// DUT response with the stored expected value and accumulates statistics.
// Optional feature macro: TV_CHECK_MASK_EN (adds a per-bit don't-care mask field
// to every vector word).
module tv_player_checker #(
    parameter int IN_W   = 5,
    parameter int OUT_W  = 2,
    parameter int DEPTH  = 101,
    parameter int ADDR_W = 7,
    parameter int SETTLE = 1
`ifdef TV_CHECK_MASK_EN
    , localparam int W   = 1 + 2 * OUT_W + IN_W
`else
    , localparam int W   = 1 + OUT_W + IN_W
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [W-1:0]      wr_data,
    input  logic              start,
    input  logic [OUT_W-1:0]  resp,
    output logic [IN_W-1:0]   stim,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [31:0]       vec_count,
    output logic [31:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [OUT_W-1:0]    exp_q, exp_d;
`ifdef TV_CHECK_MASK_EN
    logic [OUT_W-1:0]    mask_q, mask_d;
`endif
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IN_W-1:0]     stim_q, stim_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [31:0]         vec_q, vec_d;
    logic [31:0]         err_q, err_d;
    logic [ADDR_W-1:0]   ferr_q, ferr_d;

    logic [W-1:0]        mem_q [DEPTH];
    logic [W-1:0]        word_s;
    logic                mismatch_s;

    // Vector memory write port; loads are accepted only while no run is active
    always_ff @(posedge clk) begin
        if (wr_en && !busy_q && (wr_addr < ADDR_W'(DEPTH))) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Combinational read of the word at the current play address
    always_comb begin
        word_s = '0;
        if (addr_q < ADDR_W'(DEPTH)) begin
            word_s = mem_q[addr_q];
        end else begin
            word_s = '0;
        end
    end

`ifdef TV_CHECK_MASK_EN
    assign mismatch_s = (((resp ^ exp_q) & ~mask_q) != '0);
`else
    assign mismatch_s = (resp != exp_q);
`endif

    // Next-state and datapath update for the play/check sequence
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        exp_d   = exp_q;
`ifdef TV_CHECK_MASK_EN
        mask_d  = mask_q;
`endif
        cnt_d   = cnt_q;
        stim_d  = stim_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        vec_d   = vec_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    vec_d   = 32'd0;
                    err_d   = 32'd0;
                    ferr_d  = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = state_q;
                end
            end
            S_FETCH: begin
                if ((addr_q == ADDR_W'(DEPTH)) || !word_s[W-1]) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_q == 32'd0);
                    state_d = S_DONE;
                end else begin
                    stim_d  = word_s[IN_W-1:0];
                    exp_d   = word_s[IN_W+OUT_W-1:IN_W];
`ifdef TV_CHECK_MASK_EN
                    mask_d  = word_s[IN_W+2*OUT_W-1:IN_W+OUT_W];
`endif
                    cnt_d   = CNT_W'(SETTLE - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CHECK: begin
                if (mismatch_s) begin
                    if (err_q == 32'd0) begin
                        ferr_d = addr_q;
                    end else begin
                        ferr_d = ferr_q;
                    end
                    err_d = (err_q == 32'hFFFF_FFFF) ? err_q : err_q + 32'd1;
                end else begin
                    err_d = err_q;
                end
                vec_d   = (vec_q == 32'hFFFF_FFFF) ? vec_q : vec_q + 32'd1;
                addr_d  = addr_q + ADDR_W'(1);
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; async reset aborts any run in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            exp_q   <= '0;
`ifdef TV_CHECK_MASK_EN
            mask_q  <= '0;
`endif
            cnt_q   <= '0;
            stim_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            vec_q   <= 32'd0;
            err_q   <= 32'd0;
            ferr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            exp_q   <= exp_d;
`ifdef TV_CHECK_MASK_EN
            mask_q  <= mask_d;
`endif
            cnt_q   <= cnt_d;
            stim_q  <= stim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
        end
    end

    assign stim           = stim_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign vec_count      = vec_q;
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;

endmodule
